// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux scan sequencer.
package mux_scan_pkg;

    localparam int unsigned DEF_NUM_INPUTS = 5;
    localparam int unsigned DEF_SEL_W      = 3;

    // Parked select: an unused mux input that reads as 0
    localparam logic [DEF_SEL_W-1:0] SEL_PARK = 3'd7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/mux5.sv
// 5:1 select mux; selects 5..7 output 0.
module mux5 (
    input  logic [2:0] s,
    input  logic [4:0] d,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (s)
            3'd0:    y = d[0];
            3'd1:    y = d[1];
            3'd2:    y = d[2];
            3'd3:    y = d[3];
            3'd4:    y = d[4];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_scan_counter.sv
// Dwell counter (modulo DWELL) plus input index counter for the scan sequencer.
module scan_counter #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [SEL_W-1:0] index_o,
    output logic             sample_strobe_c_o
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [SEL_W-1:0] index_q, index_d;

    // Strobe marks the last dwell cycle of the current index
    assign sample_strobe_c_o = enable_i && (dwell_q == DW_W'(DWELL - 1));
    assign index_o           = index_q;

    always_comb begin
        dwell_d = dwell_q;
        index_d = index_q;
        if (clear_i) begin
            dwell_d = '0;
            index_d = '0;
        end else if (sample_strobe_c_o) begin
            dwell_d = '0;
            index_d = index_q + SEL_W'(1);
        end else if (enable_i) begin
            dwell_d = dwell_q + DW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_q <= '0;
            index_q <= '0;
        end else begin
            dwell_q <= dwell_d;
            index_q <= index_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around mux5: steps sel, samples y_in, presents a word with valid/ack.
// MUX_SCAN_CHECK_EN adds a CHECK pass on an unused select that sets a sticky err.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int unsigned SEL_W      = DEF_SEL_W,
    parameter int unsigned DWELL      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [SEL_W-1:0]      sel,
    input  logic                  y_in,
    output logic                  busy,
    output logic [NUM_INPUTS-1:0] word,
    output logic                  valid,
    input  logic                  ack,
    output logic                  err
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_INPUTS - 1);
    localparam logic [SEL_W-1:0] PARK     = SEL_W'(SEL_PARK);

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic [NUM_INPUTS-1:0]   word_q, word_d;
    logic [NUM_INPUTS-1:0]   capture_q, capture_d;
    logic [SEL_W-1:0]        index;
    logic                    strobe_c;
    logic                    cnt_en_c;
`ifdef MUX_SCAN_CHECK_EN
    logic                    err_q, err_d;
`endif

    assign cnt_en_c = (state_q == ST_SCAN) || (state_q == ST_CHECK);

    scan_counter #(
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) u_counter (
        .clk               (clk),
        .reset             (reset),
        .clear_i           (!cnt_en_c),
        .enable_i          (cnt_en_c),
        .index_o           (index),
        .sample_strobe_c_o (strobe_c)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        word_d    = word_q;
        capture_d = capture_q;
`ifdef MUX_SCAN_CHECK_EN
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    sel_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (strobe_c) begin
                    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                        if (index == SEL_W'(i)) capture_d[i] = y_in;
                    end
                    if (index != LAST_IDX) begin
                        sel_d = index + SEL_W'(1);
                    end else begin
`ifdef MUX_SCAN_CHECK_EN
                        state_d = ST_CHECK;
                        sel_d   = SEL_W'(NUM_INPUTS);
`else
                        state_d = ST_DONE;
                        sel_d   = PARK;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        word_d  = capture_d;
`endif
                    end
                end
            end
`ifdef MUX_SCAN_CHECK_EN
            ST_CHECK: begin
                // Unused select must read 0; anything else flags a mux fault
                if (strobe_c) begin
                    if (y_in) err_d = 1'b1;
                    state_d = ST_DONE;
                    sel_d   = PARK;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    word_d  = capture_q;
                end
            end
`endif
            ST_DONE: begin
                if (ack) begin
                    valid_d = 1'b0;
                    if (start) begin
                        state_d = ST_SCAN;
                        sel_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = PARK;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= PARK;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            word_q    <= '0;
            capture_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            word_q    <= word_d;
            capture_q <= capture_d;
        end
    end

`ifdef MUX_SCAN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign sel   = sel_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign word  = word_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: DWELL=1 and DWELL=3 instances, each behind a mux5.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, ack_a, force_a, mux_y_a, y_in_a;
    logic       busy_a, valid_a, err_a;
    logic [2:0] sel_a;
    logic [4:0] d_a, word_a;
    logic       start_b, ack_b, mux_y_b;
    logic       busy_b, valid_b, err_b;
    logic [2:0] sel_b;
    logic [4:0] d_b, word_b;

    int         n_vec = 0;
    int         n_err = 0;
    logic       inject_a;
    logic       exp_err;
    logic [4:0] dv;
    int         bi, bk;

    always #5 clk = ~clk;

    assign y_in_a = mux_y_a | force_a;

    mux5 u_mux_a (.s(sel_a), .d(d_a), .y(mux_y_a));
    mux5 u_mux_b (.s(sel_b), .d(d_b), .y(mux_y_b));

    mux_scan_ctrl #(.NUM_INPUTS(5), .SEL_W(3), .DWELL(1)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sel(sel_a), .y_in(y_in_a),
        .busy(busy_a), .word(word_a), .valid(valid_a), .ack(ack_a), .err(err_a)
    );

    mux_scan_ctrl #(.NUM_INPUTS(5), .SEL_W(3), .DWELL(3)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sel(sel_b), .y_in(mux_y_b),
        .busy(busy_b), .word(word_b), .valid(valid_b), .ack(ack_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a scan on instance A (optionally with ack) and follow it to the valid cycle
    task automatic scan_a(input logic [4:0] d, input logic [4:0] old_word, input logic with_ack);
        d_a     = d;
        start_a = 1'b1;
        ack_a   = with_ack;
        tick();
        start_a = 1'b0;
        ack_a   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("a_sel", 32'(sel_a), 32'(i));
            check("a_busy", 32'(busy_a), 32'd1);
            check("a_valid_low", 32'(valid_a), 32'd0);
            check("a_word_hold", 32'(word_a), 32'(old_word));
            tick();
        end
`ifdef MUX_SCAN_CHECK_EN
        check("a_sel_check", 32'(sel_a), 32'd5);
        check("a_busy_check", 32'(busy_a), 32'd1);
        force_a = inject_a;
        tick();
        force_a = 1'b0;
`endif
        check("a_valid", 32'(valid_a), 32'd1);
        check("a_word", 32'(word_a), 32'(d));
        check("a_busy_done", 32'(busy_a), 32'd0);
        check("a_sel_park", 32'(sel_a), 32'd7);
    endtask

    task automatic ack_a_now();
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        check("a_valid_cleared", 32'(valid_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start_a = 1'b0; ack_a = 1'b0; force_a = 1'b0; d_a = '0;
        start_b = 1'b0; ack_b = 1'b0; d_b = '0; inject_a = 1'b0;
`ifdef MUX_SCAN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        check("rst_sel", 32'(sel_a), 32'd7);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_word", 32'(word_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_sel_b", 32'(sel_b), 32'd7);
        tick();

        // basic scan, d0..d4 = 1,0,1,1,0
        scan_a(5'b01101, 5'b00000, 1'b0);
        check("a_err_clean", 32'(err_a), 32'd0);

        // valid held without ack; start pulses ignored
        for (int c = 0; c < 10; c++) begin
            start_a = (c % 3 == 1);
            tick();
            check("hold_valid", 32'(valid_a), 32'd1);
            check("hold_word", 32'(word_a), 32'b01101);
            check("hold_sel", 32'(sel_a), 32'd7);
        end
        start_a = 1'b0;
        ack_a_now();
        check("idle_word_kept", 32'(word_a), 32'b01101);
        tick();
        check("idle_sel", 32'(sel_a), 32'd7);
        check("idle_busy", 32'(busy_a), 32'd0);

        // back-to-back: ack and start together in DONE
        scan_a(5'b01101, 5'b01101, 1'b0);
        scan_a(5'b11111, 5'b01101, 1'b1);
        ack_a_now();
        tick();

        // reset while sel=2
        d_a = 5'b01101;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        check("mid_sel2", 32'(sel_a), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_sel", 32'(sel_a), 32'd7);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_word", 32'(word_a), 32'd0);
        check("mid_rst_valid", 32'(valid_a), 32'd0);
        tick();
        scan_a(5'b10100, 5'b00000, 1'b0);
        ack_a_now();
        tick();

        // stuck-high on the unused select during the check slot
`ifdef MUX_SCAN_CHECK_EN
        inject_a = 1'b1;
        scan_a(5'b00110, 5'b10100, 1'b0);
        inject_a = 1'b0;
`else
        scan_a(5'b00110, 5'b10100, 1'b0);
        force_a = 1'b1;
        tick();
        force_a = 1'b0;
        check("force_word_kept", 32'(word_a), 32'b00110);
`endif
        check("err_set", 32'(err_a), 32'(exp_err));
        ack_a_now();
        tick();
        scan_a(5'b01011, 5'b00110, 1'b0);
        check("err_sticky", 32'(err_a), 32'(exp_err));
        ack_a_now();

        // DWELL=3 instance; d toggled during the first two dwell cycles
        d_b = 5'b10010;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            bi = (c - 1) / 3;
            bk = (c - 1) % 3;
            check("b_sel", 32'(sel_b), 32'(bi));
            check("b_busy", 32'(busy_b), 32'd1);
            dv = 5'b10010;
            if (bk < 2) dv[bi] = ~dv[bi];
            d_b = dv;
            tick();
        end
        d_b = 5'b10010;
`ifdef MUX_SCAN_CHECK_EN
        for (int c = 0; c < 3; c++) begin
            check("b_sel_check", 32'(sel_b), 32'd5);
            tick();
        end
`endif
        check("b_valid", 32'(valid_b), 32'd1);
        check("b_word", 32'(word_b), 32'b10010);
        check("b_sel_park", 32'(sel_b), 32'd7);
        check("b_err", 32'(err_b), 32'd0);
        ack_b = 1'b1;
        tick();
        ack_b = 1'b0;
        check("b_valid_cleared", 32'(valid_b), 32'd0);

        // reset clears the sticky error and the word
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("final_rst_err", 32'(err_a), 32'd0);
        check("final_rst_word", 32'(word_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer wrapped around the 5:1 select mux (`mux5`).
- Drives the mux select `s` through 0..4, samples mux output `y` once per input, and packs the five samples into a 5-bit word.
- Presents the word to downstream logic with a valid/ack handshake.
- Sits directly upstream (owns `s`) and downstream (consumes `y`) of the mux.

Parameters:
- NUM_INPUTS, 5, number of mux data inputs scanned (indices 0..NUM_INPUTS-1).
- SEL_W, 3, width of the select bus.
- DWELL, 1, cycles each select value is held before sampling (≥1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a scan; accepted only in IDLE, or in DONE together with ack.
- sel  output  SEL_W  to mux `s`.
- y_in  input  1  from mux `y`.
- busy  output  1  high in SCAN (and CHECK).
- word  output  NUM_INPUTS  last completed scan; bit i = value of d_i.
- valid  output  1  word is new; held until ack.
- ack  input  1  consumer accepts word.
- err  output  1  sticky check-failure flag (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): state=IDLE, sel=SEL_PARK (3'd7), word=0, valid=0, busy=0, err=0, index=0, dwell count=0. Reset mid-scan aborts; the partial capture is discarded.
- States: IDLE, SCAN, CHECK (macro only), DONE.
- IDLE:
  - sel=SEL_PARK, so the mux outputs 0.
  - start=1 → SCAN next cycle with index=0.
- SCAN:
  - sel=index; busy=1.
  - Dwell counter counts 0..DWELL-1.
  - On the edge ending dwell count DWELL-1, y_in is written into capture[index], and then:
    - if index<NUM_INPUTS-1: index increments and dwell resets;
    - else: go to CHECK (macro) or DONE.
  - capture is an internal register; `word` is not disturbed during a scan.
- DONE entry: word←capture including the final sample; valid=1; busy=0; sel=SEL_PARK.
- DONE:
  - valid stays high until ack=1 is sampled.
  - ack=1, start=0 → IDLE; valid=0 next cycle.
  - ack=1, start=1 → SCAN at index 0; valid=0 next cycle.
  - start without ack is ignored.
- start during SCAN/CHECK is ignored (no queueing).
- ack outside DONE is ignored.
- Latency with start accepted in cycle 0 (no macro): sel=i during cycles 1+i·DWELL .. (i+1)·DWELL. valid first high in cycle NUM_INPUTS·DWELL+1 (=6 for defaults).
- word holds its value after ack until the next scan completes.
- index width = SEL_W. NUM_INPUTS must be ≤ 2^SEL_W−1 so that SEL_PARK is never a scanned index.

Optional Feature:
- Macro: MUX_SCAN_CHECK_EN.
- Defined:
  - After the last data index, the block enters CHECK for DWELL cycles with sel=NUM_INPUTS (3'd5), an unused mux select that must produce 0.
  - If y_in=1 at the sample edge, err is set; err is sticky until reset.
  - Then → DONE.
  - Adds DWELL cycles of latency (valid in cycle 7 for defaults).
- Not defined: no CHECK state is built; err is tied to 0; latency is as above.

Decomposition:
- Package mux_scan_pkg:
  - state enum (IDLE, SCAN, CHECK, DONE);
  - constant SEL_PARK = 3'd7;
  - default NUM_INPUTS/SEL_W.
- One sub-module, scan_counter:
  - modulo-DWELL dwell counter plus index counter;
  - outputs index and sample_strobe;
  - has clear and enable inputs.
- The FSM and capture/word registers stay in mux_scan_ctrl.
- Bench instantiates mux5 between sel and y_in.

Test Plan:
- Basic scan: reset, then d0..d4=1,0,1,1,0, pulse start → sel steps 0,1,2,3,4 in cycles 1–5; valid=1 in cycle 6; word=5'b01101.
- Valid hold: keep ack=0 for 10 cycles after valid → valid and word stay constant; start pulses in this window are ignored; ack=1 → valid=0 next cycle, state IDLE.
- Back-to-back: in DONE assert ack=1 and start=1 together with d=5'b11111 → next cycle sel=0, valid=0; valid returns 5 cycles later with word=5'b11111.
- Reset mid-scan: assert reset while sel=2 → next cycle sel=7, busy=0, word=0, valid=0; a new scan completes normally.
- DWELL=3, d=5'b10010: each sel value is held 3 cycles; valid in cycle 16; word=5'b10010; y_in is sampled only on the 3rd cycle (toggling d during the first 2 cycles has no effect).
- MUX_SCAN_CHECK_EN:
  - with the real mux, sel=5 appears in cycle 6, valid in cycle 7, err=0;
  - forcing y_in=1 during sel=5 → err=1 and stays 1 across later scans until reset.
